// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM encodings, the default
// frame marker, the imem base address and the checksum helper.
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LEN0 = 3'd1,
        LDR_LEN1 = 3'd2,
        LDR_DATA = 3'd3,
        LDR_CSUM = 3'd4,
        LDR_RUN  = 3'd5,
        LDR_ERR  = 3'd6
    } ldr_state_t;

    localparam logic [7:0]  LDR_SYNC_BYTE = 8'hA5;

    // The loader always fills the instruction memory from byte address 0.
    localparam logic [31:0] LDR_IMEM_BASE = 32'h0000_0000;

    // Modulo-256 running sum over the data bytes of a frame.
    function automatic logic [7:0] ldr_csum_add(input logic [7:0] csum,
                                                input logic [7:0] data);
        return csum + data;
    endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
interface uart_imem_loader_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [31:0]           imem_wdata;

    // Loader side: consumes bytes, drives the imem write port.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    // Environment side: UART receiver feeding bytes, imem observing writes.
    modport master (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/uart_imem_loader_timer.sv
// Inter-byte idle timer: counts enabled, non-cleared cycles and flags expiry
// once the count reaches TIMEOUT_CYCLES-1.
module loader_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Idle counter: held at zero while disabled or cleared, saturates at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr || !i_en) begin
            r_count <= {CW{1'b0}};
        end else if (r_count != LAST) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/uart_imem_loader.sv
// Boot-time loader: frames a UART byte stream, writes little-endian words into
// imem from address 0 and releases the CPU reset once the checksum matches.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 16,
    parameter int         MAX_WORDS      = 16384,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = LDR_SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_imem_loader_if.slave  bus,
    input  logic               i_reload,
    output logic               o_cpu_rst,
    output logic               o_load_done,
    output logic               o_load_error,
    output logic [15:0]        o_words_loaded
);
    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

    ldr_state_t            r_state;
    ldr_state_t            w_next_state;
    logic [15:0]           r_len;
    logic [7:0]            r_csum;
    logic [1:0]            r_byte_idx;
    logic [15:0]           r_word_idx;
    logic [23:0]           r_asm;        // bytes 0..2 of the word in flight
    logic [15:0]           r_words_loaded;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic                  r_cpu_rst;
    logic                  r_load_done;
    logic                  r_load_error;

    logic [15:0]           w_len_full;
    logic                  w_len_bad;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic                  w_timeout;
    logic                  w_tmr_clr;
    logic                  w_tmr_en;

    assign w_len_full  = {bus.rx_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > MAX_WORDS_W);
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = (r_word_idx == (r_len - 16'd1));

    // The timer only runs while a frame is in progress; any byte or state
    // change restarts the idle window.
    assign w_tmr_en  = (r_state == LDR_LEN0) || (r_state == LDR_LEN1) ||
                       (r_state == LDR_DATA) || (r_state == LDR_CSUM);
    assign w_tmr_clr = bus.rx_valid || i_reload || (w_next_state != r_state);

    loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expired(w_timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LDR_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a byte in the same cycle as a timeout wins.
    always_comb begin
        w_next_state = r_state;
        if (i_reload) begin
            w_next_state = LDR_IDLE;
        end else begin
            case (r_state)
                LDR_IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        w_next_state = LDR_LEN0;
                    end else begin
                        w_next_state = LDR_IDLE;
                    end
                end
                LDR_LEN0: begin
                    if (bus.rx_valid) begin
                        w_next_state = LDR_LEN1;
                    end else if (w_timeout) begin
                        w_next_state = LDR_ERR;
                    end else begin
                        w_next_state = LDR_LEN0;
                    end
                end
                LDR_LEN1: begin
                    if (bus.rx_valid) begin
                        w_next_state = w_len_bad ? LDR_ERR : LDR_DATA;
                    end else if (w_timeout) begin
                        w_next_state = LDR_ERR;
                    end else begin
                        w_next_state = LDR_LEN1;
                    end
                end
                LDR_DATA: begin
                    if (bus.rx_valid && w_last_byte && w_last_word) begin
                        w_next_state = LDR_CSUM;
                    end else if (!bus.rx_valid && w_timeout) begin
                        w_next_state = LDR_ERR;
                    end else begin
                        w_next_state = LDR_DATA;
                    end
                end
                LDR_CSUM: begin
                    if (bus.rx_valid) begin
                        w_next_state = (bus.rx_data == r_csum) ? LDR_RUN : LDR_ERR;
                    end else if (w_timeout) begin
                        w_next_state = LDR_ERR;
                    end else begin
                        w_next_state = LDR_CSUM;
                    end
                end
                LDR_RUN: begin
                    w_next_state = LDR_RUN;
                end
                LDR_ERR: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        w_next_state = LDR_LEN0;
                    end else begin
                        w_next_state = LDR_ERR;
                    end
                end
                default: begin
                    w_next_state = LDR_IDLE;
                end
            endcase
        end
    end

    // Datapath: length capture, word assembly, registered imem write and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len          <= 16'd0;
            r_csum         <= 8'd0;
            r_byte_idx     <= 2'd0;
            r_word_idx     <= 16'd0;
            r_asm          <= 24'd0;
            r_words_loaded <= 16'd0;
            r_we           <= 1'b0;
            r_waddr        <= {ADDR_WIDTH{1'b0}};
            r_wdata        <= 32'd0;
            r_cpu_rst      <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
        end else if (i_reload) begin
            r_byte_idx   <= 2'd0;
            r_we         <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    LDR_LEN0: begin
                        r_len[7:0] <= bus.rx_data;
                    end
                    LDR_LEN1: begin
                        r_len[15:8] <= bus.rx_data;
                        if (w_next_state == LDR_DATA) begin
                            r_csum         <= 8'd0;
                            r_byte_idx     <= 2'd0;
                            r_word_idx     <= 16'd0;
                            r_words_loaded <= 16'd0;
                        end
                    end
                    LDR_DATA: begin
                        r_csum     <= ldr_csum_add(r_csum, bus.rx_data);
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= bus.rx_data;
                            2'd1: r_asm[15:8]  <= bus.rx_data;
                            2'd2: r_asm[23:16] <= bus.rx_data;
                            default: begin
                                // Write port is separate from the assembly
                                // lanes so byte 0 of the next word can land
                                // during this write cycle.
                                r_we       <= 1'b1;
                                r_waddr    <= ADDR_WIDTH'(LDR_IMEM_BASE) +
                                              ADDR_WIDTH'({r_word_idx, 2'b00});
                                r_wdata    <= {bus.rx_data, r_asm};
                                r_word_idx <= r_word_idx + 16'd1;
                                if ({1'b0, r_words_loaded} < MAX_WORDS_W) begin
                                    r_words_loaded <= r_words_loaded + 16'd1;
                                end
                            end
                        endcase
                    end
                    LDR_CSUM: begin
                        if (w_next_state == LDR_RUN) begin
                            r_cpu_rst   <= 1'b0;
                            r_load_done <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if ((w_next_state == LDR_ERR) && (r_state != LDR_ERR)) begin
                r_load_error <= 1'b1;
            end else if ((r_state == LDR_ERR) && (w_next_state == LDR_LEN0)) begin
                r_load_error <= 1'b0;
            end
        end
    end

    assign bus.imem_we     = r_we;
    assign bus.imem_waddr  = r_waddr;
    assign bus.imem_wdata  = r_wdata;
    assign o_cpu_rst       = r_cpu_rst;
    assign o_load_done     = r_load_done;
    assign o_load_error    = r_load_error;
    assign o_words_loaded  = r_words_loaded;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: expected imem writes go into a
// scoreboard queue checked by an independent monitor; status is checked inline.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reload = 1'b0;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];

    uart_imem_loader_if #(.ADDR_WIDTH(16)) u_if ();

    uart_imem_loader #(
        .ADDR_WIDTH    (16),
        .MAX_WORDS     (16384),
        .TIMEOUT_CYCLES(100),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (u_if.slave),
        .i_reload      (reload),
        .o_cpu_rst     (cpu_rst),
        .o_load_done   (load_done),
        .o_load_error  (load_error),
        .o_words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) send_byte(frame_q[i], gap);
    endtask

    task automatic expect_wr(input logic [15:0] addr, input logic [31:0] data);
        exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Two-word program: 0x13, 0x6F; checksum 0x13+0x6F = 0x82.
    task automatic send_valid(input int gap);
        expect_wr(16'h0000, 32'h0000_0013);
        expect_wr(16'h0004, 32'h0000_006F);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_frame(gap);
    endtask

    // Scoreboard monitor: every imem write must match the oldest expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (u_if.imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write",
                             u_if.imem_waddr, u_if.imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(u_if.imem_waddr), 32'(e.addr));
                    check("wr_data", u_if.imem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check("rst_cpu_rst",    32'(cpu_rst),        32'd1);
        check("rst_load_done",  32'(load_done),      32'd0);
        check("rst_load_error", 32'(load_error),     32'd0);
        check("rst_words",      32'(words_loaded),   32'd0);
        check("rst_we",         32'(u_if.imem_we),   32'd0);
        check("rst_waddr",      32'(u_if.imem_waddr), 32'd0);
        check("rst_wdata",      u_if.imem_wdata,     32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Valid load
        send_valid(1);
        check("valid_cpu_rst",   32'(cpu_rst),      32'd0);
        check("valid_done",      32'(load_done),    32'd1);
        check("valid_error",     32'(load_error),   32'd0);
        check("valid_words",     32'(words_loaded), 32'd2);

        // Reload in RUN puts the CPU back into reset on the next cycle
        pulse_reload();
        check("reload_cpu_rst",  32'(cpu_rst),   32'd1);
        check("reload_done",     32'(load_done), 32'd0);
        send_byte(8'h13, 2);   // IDLE ignores non-sync bytes
        check("idle_ignore_err", 32'(load_error), 32'd0);

        // Bad checksum: writes still happen, frame rejected
        expect_wr(16'h0000, 32'h0000_0013);
        expect_wr(16'h0004, 32'h0000_006F);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
        send_frame(1);
        check("badcs_error",   32'(load_error), 32'd1);
        check("badcs_cpu_rst", 32'(cpu_rst),    32'd1);
        check("badcs_done",    32'(load_done),  32'd0);
        send_valid(1);
        check("resend_error",  32'(load_error), 32'd0);
        check("resend_done",   32'(load_done),  32'd1);

        // Garbage before sync
        pulse_reload();
        frame_q = '{8'h00, 8'hFF, 8'h13};
        send_frame(1);
        send_valid(0);
        check("garbage_done",  32'(load_done),    32'd1);
        check("garbage_words", 32'(words_loaded), 32'd2);

        // Zero-length frame, then an oversized one straight from ERR
        pulse_reload();
        frame_q = '{8'hA5, 8'h00, 8'h00};
        send_frame(1);
        check("len0_error", 32'(load_error), 32'd1);
        send_byte(8'hA5, 1);
        check("err_sync_clears", 32'(load_error), 32'd0);
        frame_q = '{8'h01, 8'h40};
        send_frame(1);
        check("len16385_error", 32'(load_error), 32'd1);
        check("len16385_cpu_rst", 32'(cpu_rst), 32'd1);

        // Timeout: load_error exactly 100 edges after the last byte's edge
        pulse_reload();
        frame_q = '{8'hA5, 8'h01, 8'h00};
        send_frame(1);
        send_byte(8'h13, 0);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (load_error === 1'b1) begin
                k = i;
                break;
            end
        end
        check("timeout_cycles", 32'(k), 32'd100);
        check("timeout_words",  32'(words_loaded), 32'd0);

        // Silence in IDLE never times out
        pulse_reload();
        repeat (1000) @(posedge clk);
        #1;
        check("idle_silence_error", 32'(load_error), 32'd0);
        check("idle_silence_cpu_rst", 32'(cpu_rst), 32'd1);

        // Back-to-back three-word frame; checksum 0x6E
        expect_wr(16'h0000, 32'h4433_2211);
        expect_wr(16'h0004, 32'h8877_6655);
        expect_wr(16'h0008, 32'h0403_0201);
        frame_q = '{8'hA5, 8'h03, 8'h00,
                    8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'h6E};
        send_frame(0);
        check("b2b_done",  32'(load_done),    32'd1);
        check("b2b_words", 32'(words_loaded), 32'd3);
        check("b2b_error", 32'(load_error),   32'd0);

        // Asynchronous reset mid-frame, then a fresh load from address 0
        pulse_reload();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send_frame(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cpu_rst", 32'(cpu_rst),        32'd1);
        check("midrst_done",    32'(load_done),      32'd0);
        check("midrst_error",   32'(load_error),     32'd0);
        check("midrst_words",   32'(words_loaded),   32'd0);
        check("midrst_we",      32'(u_if.imem_we),   32'd0);
        check("midrst_waddr",   32'(u_if.imem_waddr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_valid(1);
        check("postrst_done",  32'(load_done),    32'd1);
        check("postrst_words", 32'(words_loaded), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
